cpu_hazard_unit: RTL and testbench
==================================

CPU_HAZARD_UNIT -- requirements
Module: cpu_hazard_unit

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of saturating performance counters.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: ifid_opcode  input  6  opcode of instruction in IF/ID.
REQ-005 SHALL have port: ifid_rs / ifid_rt  input  5 each  source fields of IF/ID instruction.
REQ-006 SHALL have ports: id_memread_ctrl, id_regwrite_ctrl, id_regdst_ctrl  input  1 each  main-control outputs for the ID instruction.
REQ-007 SHALL have port: id_rd  input  5  rd field of the ID instruction.
REQ-008 SHALL have port: branch_taken  input  1  branch in EX resolved taken this cycle.
REQ-009 SHALL have port: cnt_clr  input  1  synchronous clear of both counters.
REQ-010 SHALL have port: hazard_detected  output  1  forces main control to no-op.
REQ-011 SHALL have ports: pc_write_en, ifid_write_en  output  1 each  PC / IF-ID register load enables.
REQ-012 SHALL have ports: ifid_flush, idex_flush  output  1 each  replace stage contents with bubble.
REQ-013 SHALL have ports: stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.
REQ-014 SHALL have port: state  output  2  FSM state, RUN=00, STALL=01, FLUSH=10.

Function
REQ-015 SHALL hold an ID/EX shadow: ex_valid, ex_memread, ex_regwrite, ex_dst[4:0].
REQ-016 On each edge, shadow SHALL load bubble (all zero) if hazard_detected or idex_flush; else load ex_valid=1, id_memread_ctrl, id_regwrite_ctrl, ex_dst = id_regdst_ctrl ? id_rd : ifid_rt.
REQ-017 rs is a source for opcodes 000000, 100011, 101011, 000100; rt is a source for 000000, 101011, 000100 only; no sources for 000010 or other opcodes.
REQ-018 load_use SHALL be ex_valid & ex_memread & ex_dst!=0 & ex_dst matches a source register of the IF/ID instruction.
REQ-019 hazard_detected, pc_write_en, ifid_write_en SHALL not depend combinationally on id_* inputs (prevents loop through main control).
REQ-020 Priority, evaluated combinationally each cycle: branch_taken > load_use > jump (ifid_opcode==000010).
REQ-021 branch_taken: ifid_flush=1, idex_flush=1, pc_write_en=1, ifid_write_en=1, hazard_detected=0.
REQ-022 load_use (no branch_taken): hazard_detected=1, pc_write_en=0, ifid_write_en=0, flushes=0; stall lasts exactly one cycle.
REQ-023 jump only: ifid_flush=1, pc_write_en=1, ifid_write_en=1, idex_flush=0, hazard_detected=0.
REQ-024 None: pc_write_en=ifid_write_en=1, all others 0.
REQ-025 FSM next state: FLUSH if branch_taken or jump, else STALL if load_use, else RUN; state is registered (reflects previous cycle's event).
REQ-026 stall_cnt SHALL increment on each load_use cycle, flush_cnt on each cycle with ifid_flush=1; both saturate at all-ones.
REQ-027 cnt_clr SHALL zero both counters; cnt_clr wins over a simultaneous increment.
REQ-028 ex_dst==0 SHALL never cause a stall, even with ex_memread=1.

Reset
REQ-029 While rst_n=0 at an edge: shadow cleared (bubble), state=RUN, stall_cnt=flush_cnt=0.
REQ-030 Outputs after reset: hazard_detected=0, pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_flush=0.
REQ-031 Reset asserted during STALL or FLUSH SHALL abandon it; first post-reset cycle is RUN with no stall.

Verification
REQ-032 lw $5 in ID (memread=1, rt=5), then add rs=5 in IF/ID -> hazard_detected=1, pc_write_en=0, ifid_write_en=0 for one cycle, stall_cnt=1, next cycle no stall.
REQ-033 lw to $0 followed by add rs=0 -> no stall, stall_cnt=0.
REQ-034 lw $7 then sw with rt=7 -> stall; lw $7 then lw with rt=7 (destination) -> no stall.
REQ-035 load_use and branch_taken same cycle -> ifid_flush=idex_flush=1, hazard_detected=0, flush_cnt+1, stall_cnt unchanged.
REQ-036 Jump opcode 000010 with rs bits = pending load dst -> ifid_flush=1 only, no stall, state=FLUSH next cycle.
REQ-037 CNT_W=4, 16 consecutive flushes -> flush_cnt=4'hF; cnt_clr with flush same cycle -> 0; rst_n=0 mid-stall -> state RUN, counters 0.

Source files
------------

// File: rtl/cpu_hazard_unit.sv
// Pipeline hazard unit: load-use stall, branch/jump flush control, a small
// ID/EX shadow of the instruction ahead, and saturating stall/flush counters.
module cpu_hazard_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       ifid_opcode,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             id_memread_ctrl,
   input  logic             id_regwrite_ctrl,
   input  logic             id_regdst_ctrl,
   input  logic [4:0]       id_rd,
   input  logic             branch_taken,
   input  logic             cnt_clr,
   output logic             hazard_detected,
   output logic             pc_write_en,
   output logic             ifid_write_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_e           state_q, state_d;
   logic             ex_valid_q, ex_valid_d;
   logic             ex_memread_q, ex_memread_d;
   logic             ex_regwrite_q, ex_regwrite_d;
   logic [4:0]       ex_dst_q, ex_dst_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic rs_used, rt_used, load_use, jump;

   // ex_regwrite is carried for a future forwarding path; nothing reads it yet.
   logic shadow_unused;
   assign shadow_unused = ex_regwrite_q;

   always_comb begin
      rs_used = 1'b0;
      rt_used = 1'b0;
      case (ifid_opcode)
         OP_RTYPE, OP_SW, OP_BEQ: begin
            rs_used = 1'b1;
            rt_used = 1'b1;
         end
         OP_LW:   rs_used = 1'b1;
         default: ;
      endcase
   end

   // Only shadow state and IF/ID fields feed the stall, never id_* control,
   // so main control can be squashed without a combinational loop.
   assign load_use = ex_valid_q && ex_memread_q && (ex_dst_q != 5'd0) &&
                     ((rs_used && (ifid_rs == ex_dst_q)) ||
                      (rt_used && (ifid_rt == ex_dst_q)));
   assign jump     = (ifid_opcode == OP_J);

   // NOTE: every output gets a default before the priority chain, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      hazard_detected = 1'b0;
      pc_write_en     = 1'b1;
      ifid_write_en   = 1'b1;
      ifid_flush      = 1'b0;
      idex_flush      = 1'b0;
      state_d         = ST_RUN;
      if (branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_d    = ST_FLUSH;
      end else if (load_use) begin
         hazard_detected = 1'b1;
         pc_write_en     = 1'b0;
         ifid_write_en   = 1'b0;
         state_d         = ST_STALL;
      end else if (jump) begin
         ifid_flush = 1'b1;
         state_d    = ST_FLUSH;
      end
   end

   always_comb begin
      ex_valid_d    = 1'b0;
      ex_memread_d  = 1'b0;
      ex_regwrite_d = 1'b0;
      ex_dst_d      = 5'd0;
      if (!(hazard_detected || idex_flush)) begin
         ex_valid_d    = 1'b1;
         ex_memread_d  = id_memread_ctrl;
         ex_regwrite_d = id_regwrite_ctrl;
         ex_dst_d      = id_regdst_ctrl ? id_rd : ifid_rt;
      end
   end

   // A stall blocked by a simultaneous branch is not counted as a stall.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (cnt_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (hazard_detected && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
         if (ifid_flush && (flush_cnt_q != '1))      flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         ex_valid_q    <= 1'b0;
         ex_memread_q  <= 1'b0;
         ex_regwrite_q <= 1'b0;
         ex_dst_q      <= 5'd0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         ex_valid_q    <= ex_valid_d;
         ex_memread_q  <= ex_memread_d;
         ex_regwrite_q <= ex_regwrite_d;
         ex_dst_q      <= ex_dst_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
   assign state     = state_q;

endmodule

// File: tb/tb_cpu_hazard_unit.sv
// Table-driven bench for cpu_hazard_unit (CNT_W=4): one record per cycle,
// expectations queued on drive and compared mid-cycle.
module tb_cpu_hazard_unit;

   localparam int CNT_W = 4;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   // {hazard_detected, pc_write_en, ifid_write_en, ifid_flush, idex_flush}
   localparam logic [4:0] C_NONE = 5'b01100;
   localparam logic [4:0] C_STL  = 5'b10000;
   localparam logic [4:0] C_BR   = 5'b01111;
   localparam logic [4:0] C_JMP  = 5'b01110;

   localparam logic [1:0] S_RUN   = 2'b00;
   localparam logic [1:0] S_STALL = 2'b01;
   localparam logic [1:0] S_FLUSH = 2'b10;

   typedef struct {
      logic [5:0]       op;
      logic [4:0]       rs;
      logic [4:0]       rt;
      logic             mr;
      logic             rdst;
      logic [4:0]       rd;
      logic             br;
      logic             clr;
      logic             rstn;
      logic [4:0]       ctrl;
      logic [1:0]       st;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [5:0]       ifid_opcode;
   logic [4:0]       ifid_rs, ifid_rt, id_rd;
   logic             id_memread_ctrl, id_regwrite_ctrl, id_regdst_ctrl;
   logic             branch_taken, cnt_clr;
   logic             hazard_detected, pc_write_en, ifid_write_en, ifid_flush, idex_flush;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [1:0]       state;

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[$];
   vec_t exp_q[$];

   cpu_hazard_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifid_opcode(ifid_opcode), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .id_memread_ctrl(id_memread_ctrl), .id_regwrite_ctrl(id_regwrite_ctrl),
      .id_regdst_ctrl(id_regdst_ctrl), .id_rd(id_rd),
      .branch_taken(branch_taken), .cnt_clr(cnt_clr),
      .hazard_detected(hazard_detected), .pc_write_en(pc_write_en),
      .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic mr,
                               logic rdst, logic [4:0] rd, logic br, logic clr, logic rstn,
                               logic [4:0] ctrl, logic [1:0] st, int sc, int fc);
      vec_t v;
      v.op = op; v.rs = rs; v.rt = rt; v.mr = mr; v.rdst = rdst; v.rd = rd;
      v.br = br; v.clr = clr; v.rstn = rstn;
      v.ctrl = ctrl; v.st = st; v.sc = CNT_W'(sc); v.fc = CNT_W'(fc);
      return v;
   endfunction

   function automatic vec_t nop(logic rstn, logic [1:0] st, int sc, int fc);
      return mk(OP_ADDI, 0, 0, 0, 0, 0, 0, 0, rstn, C_NONE, st, sc, fc);
   endfunction

   task automatic check(input string name, input int row, input logic [31:0] act,
                        input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s row %0d: got %h, expected %h", name, row, act, req);
      end
   endtask

   task automatic apply(input vec_t v, input int row);
      vec_t e;
      @(posedge clk);
      #1;
      ifid_opcode      = v.op;
      ifid_rs          = v.rs;
      ifid_rt          = v.rt;
      id_memread_ctrl  = v.mr;
      id_regwrite_ctrl = v.mr | v.rdst;
      id_regdst_ctrl   = v.rdst;
      id_rd            = v.rd;
      branch_taken     = v.br;
      cnt_clr          = v.clr;
      rst_n            = v.rstn;
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      check("ctrl", row, 32'({hazard_detected, pc_write_en, ifid_write_en, ifid_flush, idex_flush}),
            32'(e.ctrl));
      check("state", row, 32'(state), 32'(e.st));
      check("stall_cnt", row, 32'(stall_cnt), 32'(e.sc));
      check("flush_cnt", row, 32'(flush_cnt), 32'(e.fc));
   endtask

   initial begin
      // Reset with idle IF/ID and a basic load/use pair.
      vecs.push_back(nop(0, S_RUN, 0, 0));
      vecs.push_back(nop(1, S_RUN, 0, 0));
      vecs.push_back(mk(OP_LW,   0, 5, 1, 0, 0, 0, 0, 1, C_NONE, S_RUN,   0, 0));
      vecs.push_back(mk(OP_R,    5, 0, 0, 1, 9, 0, 0, 1, C_STL,  S_RUN,   0, 0));
      vecs.push_back(mk(OP_R,    5, 0, 0, 1, 9, 0, 0, 1, C_NONE, S_STALL, 1, 0));
      // Load to $0 never stalls.
      vecs.push_back(mk(OP_LW,   0, 0, 1, 0, 0, 0, 0, 1, C_NONE, S_RUN,   1, 0));
      vecs.push_back(mk(OP_R,    0, 0, 0, 1, 9, 0, 0, 1, C_NONE, S_RUN,   1, 0));
      // sw rt is a source, lw rt is not.
      vecs.push_back(mk(OP_LW,   0, 7, 1, 0, 0, 0, 0, 1, C_NONE, S_RUN,   1, 0));
      vecs.push_back(mk(OP_SW,   0, 7, 0, 0, 0, 0, 0, 1, C_STL,  S_RUN,   1, 0));
      vecs.push_back(nop(1, S_STALL, 2, 0));
      vecs.push_back(mk(OP_LW,   0, 7, 1, 0, 0, 0, 0, 1, C_NONE, S_RUN,   2, 0));
      vecs.push_back(mk(OP_LW,   0, 7, 1, 0, 0, 0, 0, 1, C_NONE, S_RUN,   2, 0));
      // Branch beats a simultaneous load-use; stall count unchanged.
      vecs.push_back(mk(OP_R,    7, 0, 0, 1, 9, 1, 0, 1, C_BR,   S_RUN,   2, 0));
      vecs.push_back(nop(1, S_FLUSH, 2, 1));
      // Jump whose rs bits match the pending load: flush only.
      vecs.push_back(mk(OP_LW,   0, 3, 1, 0, 0, 0, 0, 1, C_NONE, S_RUN,   2, 1));
      vecs.push_back(mk(OP_J,    3, 3, 0, 0, 0, 0, 0, 1, C_JMP,  S_RUN,   2, 1));
      vecs.push_back(nop(1, S_FLUSH, 2, 2));
      // beq rt source, addi has no sources, dst taken from rd.
      vecs.push_back(mk(OP_LW,   0, 4, 1, 0, 0, 0, 0, 1, C_NONE, S_RUN,   2, 2));
      vecs.push_back(mk(OP_BEQ,  0, 4, 0, 0, 0, 0, 0, 1, C_STL,  S_RUN,   2, 2));
      vecs.push_back(nop(1, S_STALL, 3, 2));
      vecs.push_back(mk(OP_LW,   0, 6, 1, 0, 0, 0, 0, 1, C_NONE, S_RUN,   3, 2));
      vecs.push_back(mk(OP_ADDI, 6, 6, 0, 0, 0, 0, 0, 1, C_NONE, S_RUN,   3, 2));
      vecs.push_back(mk(OP_R,    0, 0, 1, 1, 8, 0, 0, 1, C_NONE, S_RUN,   3, 2));
      vecs.push_back(mk(OP_R,    0, 8, 0, 1, 9, 0, 0, 1, C_STL,  S_RUN,   3, 2));
      vecs.push_back(nop(1, S_STALL, 4, 2));
      // 16 back-to-back branch flushes saturate the 4-bit flush counter.
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk(OP_ADDI, 0, 0, 0, 0, 0, 1, 0, 1, C_BR,
                           (i == 0) ? S_RUN : S_FLUSH, 4, (2 + i > 15) ? 15 : 2 + i));
      // Clear wins over a simultaneous flush increment.
      vecs.push_back(mk(OP_ADDI, 0, 0, 0, 0, 0, 1, 1, 1, C_BR, S_FLUSH, 4, 15));
      vecs.push_back(nop(1, S_FLUSH, 0, 0));
      // Reset while in STALL state, and reset on the stall cycle itself.
      vecs.push_back(mk(OP_LW,   0, 5, 1, 0, 0, 0, 0, 1, C_NONE, S_RUN,   0, 0));
      vecs.push_back(mk(OP_R,    5, 0, 0, 1, 9, 0, 0, 1, C_STL,  S_RUN,   0, 0));
      vecs.push_back(nop(0, S_STALL, 1, 0));
      vecs.push_back(nop(1, S_RUN, 0, 0));
      vecs.push_back(mk(OP_LW,   0, 5, 1, 0, 0, 0, 0, 1, C_NONE, S_RUN,   0, 0));
      vecs.push_back(mk(OP_R,    5, 0, 0, 1, 9, 0, 0, 0, C_STL,  S_RUN,   0, 0));
      vecs.push_back(mk(OP_R,    5, 0, 0, 1, 9, 0, 0, 1, C_NONE, S_RUN,   0, 0));
      vecs.push_back(nop(1, S_RUN, 0, 0));

      rst_n = 1'b0;
      ifid_opcode = OP_ADDI; ifid_rs = '0; ifid_rt = '0; id_rd = '0;
      id_memread_ctrl = 1'b0; id_regwrite_ctrl = 1'b0; id_regdst_ctrl = 1'b0;
      branch_taken = 1'b0; cnt_clr = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
